// File: rtl/control_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer driving the datapath's bus selects, load strobes and memory handshake.
// Build option: define SEQ_TRAP_EN to halt with a sticky illegal flag on unrecognised opcodes.
module control_sequencer #(
    parameter int             OPW      = 5,
    parameter int             LINK_REG = 15,
    parameter logic [OPW-1:0] NOP_OP   = 5'b11001
) (
    input  logic           clk,
    input  logic           clear,
    input  logic [31:0]    ir,
    input  logic           brn_flag,
    input  logic           mem_ready,
    output logic [OPW-1:0] opcode,
    output logic           incPC,
    output logic [3:0]     bus_src,
    output logic [10:0]    ld_en,
    output logic [1:0]     reg_sel,
    output logic           mem_read,
    output logic           mem_write,
    output logic           run,
    output logic           illegal
);

    localparam logic [OPW-1:0] OP_LDW  = OPW'(0),  OP_LDWI = OPW'(1),  OP_STW  = OPW'(2),
                               OP_ADD  = OPW'(3),  OP_SUB  = OPW'(4),  OP_SHR  = OPW'(5),
                               OP_SHL  = OPW'(6),  OP_ROR  = OPW'(7),  OP_ROL  = OPW'(8),
                               OP_AND  = OPW'(9),  OP_OR   = OPW'(10), OP_ADDI = OPW'(11),
                               OP_ANDI = OPW'(12), OP_ORI  = OPW'(13), OP_MUL  = OPW'(14),
                               OP_DIV  = OPW'(15), OP_NEG  = OPW'(16), OP_NOT  = OPW'(17),
                               OP_BRN  = OPW'(18), OP_JR   = OPW'(19), OP_JAL  = OPW'(20),
                               OP_IN   = OPW'(21), OP_OUT  = OPW'(22), OP_MFHI = OPW'(23),
                               OP_MFLO = OPW'(24), OP_NOP  = OPW'(25), OP_HALT = OPW'(26);

    localparam logic [3:0] B_NONE = 4'd0, B_PC  = 4'd1, B_MDR = 4'd2, B_ZLO    = 4'd3,
                           B_ZHI  = 4'd4, B_HI  = 4'd5, B_LO  = 4'd6, B_INPORT = 4'd7,
                           B_C    = 4'd8, B_RSEL = 4'd9, B_RBA = 4'd10;

    localparam int LD_PC = 0, LD_MAR = 1, LD_MDR = 2, LD_IR = 3, LD_Y = 4, LD_Z = 5,
                   LD_HI = 6, LD_LO = 7, LD_R = 8, LD_CON = 9, LD_OUT = 10;

    localparam logic [1:0] RS_GRA = 2'd0, RS_GRB = 2'd1, RS_GRC = 2'd2, RS_LINK = 2'd3;

    typedef enum logic [3:0] {
        S_F0, S_F1, S_F2, S_F3, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    typedef enum logic [4:0] {
        C_ALU3, C_IMM, C_MULDIV, C_UNARY, C_LDW, C_LDWI, C_STW, C_BRANCH,
        C_JR, C_JAL, C_MFHI, C_MFLO, C_IN, C_OUT, C_NOP, C_HALT, C_BAD
    } iclass_t;

    state_t         state, state_n;
    iclass_t        iclass;
    logic           run_q;
    logic [OPW-1:0] op;

    assign op = ir[31 -: OPW];

    // brn_flag steers the ALU; the step sequence is identical for taken and not-taken branches.
    logic unused_ok;
    assign unused_ok = &{1'b0, ir[31-OPW:0], brn_flag, LINK_REG[3:0]};

    function automatic state_t next_step(input state_t s);
        case (s)
            S_T3:    return S_T4;
            S_T4:    return S_T5;
            S_T5:    return S_T6;
            S_T6:    return S_T7;
            default: return S_F0;
        endcase
    endfunction

    always_comb begin
        case (op)
            OP_ADD, OP_SUB, OP_SHR, OP_SHL,
            OP_ROR, OP_ROL, OP_AND, OP_OR:  iclass = C_ALU3;
            OP_ADDI, OP_ANDI, OP_ORI:       iclass = C_IMM;
            OP_MUL, OP_DIV:                 iclass = C_MULDIV;
            OP_NEG, OP_NOT:                 iclass = C_UNARY;
            OP_LDW:                         iclass = C_LDW;
            OP_LDWI:                        iclass = C_LDWI;
            OP_STW:                         iclass = C_STW;
            OP_BRN:                         iclass = C_BRANCH;
            OP_JR:                          iclass = C_JR;
            OP_JAL:                         iclass = C_JAL;
            OP_MFHI:                        iclass = C_MFHI;
            OP_MFLO:                        iclass = C_MFLO;
            OP_IN:                          iclass = C_IN;
            OP_OUT:                         iclass = C_OUT;
            OP_NOP:                         iclass = C_NOP;
            OP_HALT:                        iclass = C_HALT;
            default:                        iclass = C_BAD;
        endcase
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state <= S_F0;
            run_q <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            state <= state_n;
            run_q <= 1'b1;
        end
    end

`ifdef SEQ_TRAP_EN
    logic trap, illegal_q;

    always_ff @(posedge clk or negedge clear) begin
        if (!clear)    illegal_q <= 1'b0;
        else if (trap) illegal_q <= 1'b1;
    end

    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

    assign run = run_q && (state != S_HALT);

    always_comb begin
        // NOTE: every output is defaulted first so no branch can leave one unassigned and infer a latch.
        state_n   = state;
        opcode    = NOP_OP;
        incPC     = 1'b0;
        bus_src   = B_NONE;
        ld_en     = '0;
        reg_sel   = RS_GRA;
        mem_read  = 1'b0;
        mem_write = 1'b0;
`ifdef SEQ_TRAP_EN
        trap      = 1'b0;
`endif
        if (run_q) begin
            case (state)
                S_F0: begin
                    bus_src        = B_PC;
                    ld_en[LD_MAR]  = 1'b1;
                    ld_en[LD_Z]    = 1'b1;
                    incPC          = 1'b1;
                    opcode         = OP_ADD;
                    state_n        = S_F1;
                end
                S_F1: begin
                    mem_read       = 1'b1;
                    ld_en[LD_MDR]  = 1'b1;
                    if (mem_ready) state_n = S_F2;
                end
                S_F2: begin
                    bus_src        = B_ZLO;
                    ld_en[LD_PC]   = 1'b1;
                    state_n        = S_F3;
                end
                S_F3: begin
                    bus_src        = B_MDR;
                    ld_en[LD_IR]   = 1'b1;
                    state_n        = S_T3;
                end
                S_HALT: ;
                default: begin
                    state_n = next_step(state);
                    case (iclass)
                        C_ALU3, C_IMM: begin
                            case (state)
                                S_T3: begin bus_src = B_RSEL; reg_sel = RS_GRB; ld_en[LD_Y] = 1'b1; end
                                S_T4: begin
                                    bus_src     = (iclass == C_IMM) ? B_C : B_RSEL;
                                    reg_sel     = RS_GRC;
                                    opcode      = op;
                                    ld_en[LD_Z] = 1'b1;
                                end
                                default: begin
                                    bus_src = B_ZLO; reg_sel = RS_GRA; ld_en[LD_R] = 1'b1; state_n = S_F0;
                                end
                            endcase
                        end
                        C_MULDIV: begin
                            case (state)
                                S_T3: begin bus_src = B_RSEL; reg_sel = RS_GRA; ld_en[LD_Y] = 1'b1; end
                                S_T4: begin bus_src = B_RSEL; reg_sel = RS_GRB; opcode = op; ld_en[LD_Z] = 1'b1; end
                                S_T5: begin bus_src = B_ZLO; ld_en[LD_LO] = 1'b1; end
                                default: begin bus_src = B_ZHI; ld_en[LD_HI] = 1'b1; state_n = S_F0; end
                            endcase
                        end
                        C_UNARY: begin
                            if (state == S_T3) begin
                                bus_src = B_RSEL; reg_sel = RS_GRB; opcode = op; ld_en[LD_Z] = 1'b1;
                            end else begin
                                bus_src = B_ZLO; reg_sel = RS_GRA; ld_en[LD_R] = 1'b1; state_n = S_F0;
                            end
                        end
                        C_LDW, C_LDWI, C_STW: begin
                            case (state)
                                S_T3: begin bus_src = B_RBA; reg_sel = RS_GRB; ld_en[LD_Y] = 1'b1; end
                                S_T4: begin bus_src = B_C; opcode = OP_ADD; ld_en[LD_Z] = 1'b1; end
                                S_T5: begin
                                    bus_src = B_ZLO;
                                    if (iclass == C_LDWI) begin
                                        reg_sel = RS_GRA; ld_en[LD_R] = 1'b1; state_n = S_F0;
                                    end else begin
                                        ld_en[LD_MAR] = 1'b1;
                                    end
                                end
                                S_T6: begin
                                    ld_en[LD_MDR] = 1'b1;
                                    if (iclass == C_LDW) begin
                                        mem_read = 1'b1;
                                        if (!mem_ready) state_n = S_T6;
                                    end else begin
                                        bus_src = B_RSEL; reg_sel = RS_GRA;
                                    end
                                end
                                default: begin
                                    if (iclass == C_LDW) begin
                                        bus_src = B_MDR; reg_sel = RS_GRA; ld_en[LD_R] = 1'b1; state_n = S_F0;
                                    end else begin
                                        mem_write = 1'b1;
                                        state_n   = mem_ready ? S_F0 : S_T7;
                                    end
                                end
                            endcase
                        end
                        C_BRANCH: begin
                            case (state)
                                S_T3: begin bus_src = B_RSEL; reg_sel = RS_GRA; ld_en[LD_CON] = 1'b1; end
                                S_T4: begin bus_src = B_PC; ld_en[LD_Y] = 1'b1; end
                                S_T5: begin bus_src = B_C; opcode = op; ld_en[LD_Z] = 1'b1; end
                                default: begin bus_src = B_ZLO; ld_en[LD_PC] = 1'b1; state_n = S_F0; end
                            endcase
                        end
                        C_JR: begin
                            bus_src = B_RSEL; reg_sel = RS_GRA; ld_en[LD_PC] = 1'b1; state_n = S_F0;
                        end
                        C_JAL: begin
                            if (state == S_T3) begin
                                bus_src = B_PC; reg_sel = RS_LINK; ld_en[LD_R] = 1'b1;
                            end else begin
                                bus_src = B_RSEL; reg_sel = RS_GRA; ld_en[LD_PC] = 1'b1; state_n = S_F0;
                            end
                        end
                        C_MFHI: begin bus_src = B_HI; reg_sel = RS_GRA; ld_en[LD_R] = 1'b1; state_n = S_F0; end
                        C_MFLO: begin bus_src = B_LO; reg_sel = RS_GRA; ld_en[LD_R] = 1'b1; state_n = S_F0; end
                        C_IN:   begin bus_src = B_INPORT; reg_sel = RS_GRA; ld_en[LD_R] = 1'b1; state_n = S_F0; end
                        C_OUT:  begin bus_src = B_RSEL; reg_sel = RS_GRA; ld_en[LD_OUT] = 1'b1; state_n = S_F0; end
                        C_HALT: state_n = S_HALT;
                        C_BAD: begin
`ifdef SEQ_TRAP_EN
                            trap    = 1'b1;
                            state_n = S_HALT;
`else
                            state_n = S_F0;
`endif
                        end
                        default: state_n = S_F0;
                    endcase
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: stimulus pushes per-cycle expected outputs, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_control_sequencer;

    localparam logic [4:0]  NOP = 5'b11001, ADD = 5'b00011;
    localparam logic [3:0]  B0 = 4'd0, BPC = 4'd1, BMDR = 4'd2, BZLO = 4'd3, BZHI = 4'd4, BHI = 4'd5,
                            BLO = 4'd6, BIN = 4'd7, BC = 4'd8, BR = 4'd9, BRBA = 4'd10;
    localparam logic [10:0] NONE  = 11'h000, PCIN = 11'h001, MARIN = 11'h002, MDRIN = 11'h004,
                            IRIN  = 11'h008, YIN  = 11'h010, ZIN   = 11'h020, HIIN  = 11'h040,
                            LOIN  = 11'h080, RIN  = 11'h100, CONIN = 11'h200, OUTIN = 11'h400;
    localparam logic [1:0]  GA = 2'd0, GB = 2'd1, GC = 2'd2, GL = 2'd3;

    typedef struct packed {
        logic [4:0]  op;
        logic        inc;
        logic [3:0]  bus;
        logic [10:0] ld;
        logic [1:0]  rs;
        logic        mr;
        logic        mw;
        logic        run;
        logic        ill;
    } rec_t;

    logic        clk = 1'b0;
    logic        clear = 1'b0;
    logic [31:0] ir = 32'h0;
    logic        brn_flag = 1'b0;
    logic        mem_ready = 1'b0;
    logic [4:0]  opcode;
    logic        incPC;
    logic [3:0]  bus_src;
    logic [10:0] ld_en;
    logic [1:0]  reg_sel;
    logic        mem_read, mem_write, run, illegal;

    control_sequencer dut (
        .clk(clk), .clear(clear), .ir(ir), .brn_flag(brn_flag), .mem_ready(mem_ready),
        .opcode(opcode), .incPC(incPC), .bus_src(bus_src), .ld_en(ld_en), .reg_sel(reg_sel),
        .mem_read(mem_read), .mem_write(mem_write), .run(run), .illegal(illegal)
    );

    always #5 clk = ~clk;

    rec_t  sb[$];
    rec_t  mon_want, mon_got;
    int    tests_run = 0;
    int    tests_failed = 0;
    int    cyc = 0;
    string cur = "reset";
    logic  exp_run = 1'b0;
    logic  exp_ill = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check(input logic ok, input string what);
        tests_run++;
        if (ok !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s cycle %0d: %s", cur, cyc, what);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_want = sb.pop_front();
            mon_got  = '{opcode, incPC, bus_src, ld_en, reg_sel, mem_read, mem_write, run, illegal};
            // reg_sel only matters when a register is driven onto the bus or loaded
            if (!(mon_want.bus == BR || mon_want.bus == BRBA || mon_want.ld[8])) begin
                mon_want.rs = 2'd0;
                mon_got.rs  = 2'd0;
            end
            check(mon_got === mon_want, "per-cycle output record");
            if (mon_got !== mon_want) begin
                $display("     got op=%b inc=%b bus=%0d ld=%h rs=%0d rd=%b wr=%b run=%b ill=%b, expected op=%b inc=%b bus=%0d ld=%h rs=%0d rd=%b wr=%b run=%b ill=%b",
                         mon_got.op, mon_got.inc, mon_got.bus, mon_got.ld, mon_got.rs, mon_got.mr,
                         mon_got.mw, mon_got.run, mon_got.ill, mon_want.op, mon_want.inc, mon_want.bus,
                         mon_want.ld, mon_want.rs, mon_want.mr, mon_want.mw, mon_want.run, mon_want.ill);
            end
        end
    end

    function automatic rec_t rec(input logic [4:0] op, input logic inc, input logic [3:0] bus,
                                 input logic [10:0] ld, input logic [1:0] rs, input logic mr, input logic mw);
        rec_t r;
        r.op = op; r.inc = inc; r.bus = bus; r.ld = ld; r.rs = rs;
        r.mr = mr; r.mw = mw; r.run = exp_run; r.ill = exp_ill;
        return r;
    endfunction

    function automatic rec_t s(input logic [3:0] bus, input logic [10:0] ld, input logic [1:0] rs);
        return rec(NOP, 1'b0, bus, ld, rs, 1'b0, 1'b0);
    endfunction

    function automatic rec_t so(input logic [4:0] op, input logic [3:0] bus, input logic [10:0] ld, input logic [1:0] rs);
        return rec(op, 1'b0, bus, ld, rs, 1'b0, 1'b0);
    endfunction

    function automatic rec_t idle();
        return s(B0, NONE, GA);
    endfunction

    function automatic rec_t rd();
        return rec(NOP, 1'b0, B0, MDRIN, GA, 1'b1, 1'b0);
    endfunction

    function automatic rec_t wr();
        return rec(NOP, 1'b0, B0, NONE, GA, 1'b0, 1'b1);
    endfunction

    function automatic rec_t f0();
        return rec(ADD, 1'b1, BPC, MARIN | ZIN, GA, 1'b0, 1'b0);
    endfunction

    task automatic step(input rec_t r, input logic rdy);
        mem_ready = rdy;
        sb.push_back(r);
        @(posedge clk);
        #1;
    endtask

    // Async clear mid-cycle, one held cycle, then a release cycle still showing reset outputs.
    task automatic do_reset();
        exp_run = 1'b0;
        exp_ill = 1'b0;
        sb.push_back(idle());
        #1 clear = 1'b0;
        #1;
        check(mem_read === 1'b0, "mem_read dropped at once by clear");
        check(opcode === NOP, "opcode forced to NOP_OP at once by clear");
        check(run === 1'b0, "run dropped at once by clear");
        @(posedge clk);
        #1;
        step(idle(), 1'b1);
        clear = 1'b1;
        step(idle(), 1'b0);
        exp_run = 1'b1;
    endtask

    task automatic fetch(input logic [4:0] op, input string name);
        cur = name;
        ir  = {op, 27'h0};
        step(f0(), 1'b0);
        step(rd(), 1'b1);
        step(s(BZLO, PCIN, GA), 1'b0);
        step(s(BMDR, IRIN, GA), 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(posedge clk);
        #1;
        cur = "reset";
        do_reset();

        cur = "add";
        ir  = 32'h1889_8000;
        step(f0(), 1'b0);
        step(rd(), 1'b1);
        step(s(BZLO, PCIN, GA), 1'b0);
        step(s(BMDR, IRIN, GA), 1'b0);
        step(s(BR, YIN, GB), 1'b0);
        step(so(ADD, BR, ZIN, GC), 1'b0);
        step(s(BZLO, RIN, GA), 1'b0);

        cur = "f1_abort";
        ir  = 32'h0;
        step(f0(), 1'b0);
        step(rd(), 1'b0);
        check(mem_read === 1'b1, "mem_read held in F1 before clear");
        do_reset();

        fetch(5'b01110, "mul");
        step(s(BR, YIN, GA), 1'b0);
        step(so(5'b01110, BR, ZIN, GB), 1'b0);
        step(s(BZLO, LOIN, GA), 1'b0);
        step(s(BZHI, HIIN, GA), 1'b0);

        fetch(5'b01111, "div");
        step(s(BR, YIN, GA), 1'b0);
        step(so(5'b01111, BR, ZIN, GB), 1'b0);
        step(s(BZLO, LOIN, GA), 1'b0);
        step(s(BZHI, HIIN, GA), 1'b0);

        fetch(5'b00000, "ldw");
        step(s(BRBA, YIN, GB), 1'b0);
        step(so(ADD, BC, ZIN, GA), 1'b0);
        step(s(BZLO, MARIN, GA), 1'b0);
        repeat (3) step(rd(), 1'b0);
        step(rd(), 1'b1);
        step(s(BMDR, RIN, GA), 1'b0);

        fetch(5'b00001, "ldwi");
        step(s(BRBA, YIN, GB), 1'b0);
        step(so(ADD, BC, ZIN, GA), 1'b0);
        step(s(BZLO, RIN, GA), 1'b0);

        fetch(5'b00010, "stw");
        step(s(BRBA, YIN, GB), 1'b0);
        step(so(ADD, BC, ZIN, GA), 1'b0);
        step(s(BZLO, MARIN, GA), 1'b0);
        step(s(BR, MDRIN, GA), 1'b0);
        step(wr(), 1'b0);
        step(wr(), 1'b1);

        brn_flag = 1'b1;
        fetch(5'b10010, "branch_taken");
        step(s(BR, CONIN, GA), 1'b0);
        step(s(BPC, YIN, GA), 1'b0);
        step(so(5'b10010, BC, ZIN, GA), 1'b0);
        step(s(BZLO, PCIN, GA), 1'b0);

        brn_flag = 1'b0;
        fetch(5'b10010, "branch_not_taken");
        step(s(BR, CONIN, GA), 1'b0);
        step(s(BPC, YIN, GA), 1'b0);
        step(so(5'b10010, BC, ZIN, GA), 1'b0);
        step(s(BZLO, PCIN, GA), 1'b0);

        fetch(5'b10011, "jr");
        step(s(BR, PCIN, GA), 1'b0);

        fetch(5'b10100, "jal");
        step(s(BPC, RIN, GL), 1'b0);
        step(s(BR, PCIN, GA), 1'b0);

        fetch(5'b10111, "mfhi");
        step(s(BHI, RIN, GA), 1'b0);
        fetch(5'b11000, "mflo");
        step(s(BLO, RIN, GA), 1'b0);
        fetch(5'b10101, "in");
        step(s(BIN, RIN, GA), 1'b0);
        fetch(5'b10110, "out");
        step(s(BR, OUTIN, GA), 1'b0);

        fetch(5'b01011, "addi");
        step(s(BR, YIN, GB), 1'b0);
        step(so(5'b01011, BC, ZIN, GA), 1'b0);
        step(s(BZLO, RIN, GA), 1'b0);

        fetch(5'b00100, "sub");
        step(s(BR, YIN, GB), 1'b0);
        step(so(5'b00100, BR, ZIN, GC), 1'b0);
        step(s(BZLO, RIN, GA), 1'b0);

        fetch(5'b10000, "neg");
        step(so(5'b10000, BR, ZIN, GB), 1'b0);
        step(s(BZLO, RIN, GA), 1'b0);

        fetch(5'b11001, "nop");
        step(idle(), 1'b1);

        fetch(5'b11111, "unknown_op");
        step(idle(), 1'b0);
`ifdef SEQ_TRAP_EN
        exp_run = 1'b0;
        exp_ill = 1'b1;
        check(illegal === 1'b1, "illegal set after unknown opcode");
        repeat (3) step(idle(), 1'b1);
        do_reset();
`else
        check(illegal === 1'b0, "illegal tied low without trap option");
`endif

        fetch(5'b11010, "halt");
        step(idle(), 1'b0);
        exp_run = 1'b0;
        step(idle(), 1'b1);
        step(idle(), 1'b0);
        step(idle(), 1'b1);
        step(idle(), 1'b0);
        check(run === 1'b0, "run stays low after halt");
        check((mem_read | mem_write) === 1'b0, "no memory request while halted");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
